// File: rtl/fifo_ext.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds, optional FWFT read and sticky errors.
// Write visible from the same edge; registered read adds one edge (FWFT: none); full/empty reject ops and set errors.
module fifo_ext #(
  parameter int WORD_BITS = 8,
  parameter int ADDR_BITS = 4,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 2**ADDR_BITS-1,
  parameter int AE_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic                 read,
  input  logic                 clear_err,
  output logic [WORD_BITS-1:0] rdata,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AF_C    = (ADDR_BITS+1)'(AF_THRESH);
  localparam logic [ADDR_BITS:0] AE_C    = (ADDR_BITS+1)'(AE_THRESH);

  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS:0]   wptr, rptr;
  logic                 rd_ok, wr_ok;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign rd_ok = read & ~empty;
  assign wr_ok = write & (~full | rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_BITS-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error in the same cycle as clear_err takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write && !wr_ok)  overflow <= 1'b1;
      else if (clear_err)   overflow <= 1'b0;
      if (read && !rd_ok)   underflow <= 1'b1;
      else if (clear_err)   underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = mem[rptr[ADDR_BITS-1:0]];
    end else begin : g_reg
      logic [WORD_BITS-1:0] rdata_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)     rdata_q <= '0;
        else if (rd_ok) rdata_q <= mem[rptr[ADDR_BITS-1:0]];
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_ext.sv
// Bench for fifo_ext: table of vectors on a registered-read instance with a data scoreboard,
// plus hand sequences for FWFT, asynchronous reset and error-flag corners.
module tb_fifo_ext;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write = 1'b0, read = 1'b0, clear_err = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;

  logic       w1 = 1'b0, r1 = 1'b0, c1 = 1'b0;
  logic [7:0] wd1 = 8'h00;
  logic [7:0] rdata1;
  logic       empty1, full1, ae1, af1, ovf1, udf1;
  logic [4:0] count1;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fifo_ext #(.WORD_BITS(8), .ADDR_BITS(4), .FWFT(0)) dut (
    .clk(clk), .reset(reset), .write(write), .wdata(wdata), .read(read),
    .clear_err(clear_err), .rdata(rdata), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow));

  fifo_ext #(.WORD_BITS(8), .ADDR_BITS(4), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .write(w1), .wdata(wd1), .read(r1),
    .clear_err(c1), .rdata(rdata1), .empty(empty1), .full(full1),
    .almost_empty(ae1), .almost_full(af1), .count(count1),
    .overflow(ovf1), .underflow(udf1));

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] wd;
    int         cnt;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(logic wr, logic rd, logic clr, logic [7:0] wd,
                              int cnt, logic ovf, logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.wd = wd;
    v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         mcount;
    logic [7:0] last_rd;
    logic [7:0] exp_rd;
    bit         wr_m, rd_m;
    string      tag;

    // Fill / overflow / drain / underflow
    for (int i = 1; i <= 16; i++) add(1, 0, 0, 8'(i), i, 0, 0);
    add(1, 0, 0, 8'd17, 16, 1, 0);
    add(0, 0, 1, 8'h00, 16, 0, 0);
    for (int i = 1; i <= 16; i++) add(0, 1, 0, 8'h00, 16 - i, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 1);
    add(0, 0, 1, 8'h00, 0, 0, 0);
    // Wrap-around
    for (int i = 0; i < 10; i++) add(1, 0, 0, 8'(8'h10 + i), i + 1, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 8'h00, 9 - i, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 0, 0, 8'(8'hA0 + i), i + 1, 0, 0);
    // Simultaneous at full, drain, simultaneous at empty
    add(1, 1, 0, 8'hB0, 16, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 8'h00, 15 - i, 0, 0);
    add(1, 1, 0, 8'hC0, 1, 0, 1);
    add(0, 1, 1, 8'h00, 0, 0, 0);
    // clear_err and a fresh underflow together: the set wins
    add(0, 1, 1, 8'h00, 0, 0, 1);
    add(0, 0, 1, 8'h00, 0, 0, 0);

    // Reset state, observed without any clock edge mattering
    #3;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b1;

    mcount  = 0;
    last_rd = 8'h00;
    for (int k = 0; k < vecs.size(); k++) begin
      write = vecs[k].wr; read = vecs[k].rd;
      clear_err = vecs[k].clr; wdata = vecs[k].wd;
      rd_m = vecs[k].rd && (mcount > 0);
      wr_m = vecs[k].wr && ((mcount < 16) || rd_m);
      exp_rd = last_rd;
      if (rd_m) begin
        if (sb.size() == 0) begin
          failed++; tests++;
          $display("FAIL sb_underrun: got empty scoreboard expected data at vec %0d", k);
        end else exp_rd = sb.pop_front();
      end
      if (wr_m) sb.push_back(vecs[k].wd);
      mcount = mcount + int'(wr_m) - int'(rd_m);
      last_rd = exp_rd;
      @(posedge clk);
      #1;
      tag = $sformatf("v%0d", k);
      chk({tag, "_count"}, count, vecs[k].cnt);
      chk({tag, "_empty"}, empty, int'(vecs[k].cnt == 0));
      chk({tag, "_full"},  full,  int'(vecs[k].cnt == 16));
      chk({tag, "_af"},    almost_full,  int'(vecs[k].cnt >= 15));
      chk({tag, "_ae"},    almost_empty, int'(vecs[k].cnt <= 1));
      chk({tag, "_ovf"},   overflow,  vecs[k].ovf);
      chk({tag, "_udf"},   underflow, vecs[k].udf);
      chk({tag, "_rdata"}, rdata, exp_rd);
    end
    write = 0; read = 0; clear_err = 0;

    // Asynchronous reset with count=5, then a read underflows
    for (int i = 0; i < 5; i++) begin
      write = 1; wdata = 8'(8'h30 + i);
      @(posedge clk); #1;
    end
    write = 0;
    chk("pre_rst_count", count, 5);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    read = 1;
    @(posedge clk); #1;
    read = 0;
    chk("post_rst_udf", underflow, 1);
    chk("post_rst_count", count, 0);

    // FWFT: write at edge N is visible after N with no read
    w1 = 1; wd1 = 8'h55;
    @(posedge clk); #1;
    w1 = 0;
    chk("fwft_rdata", rdata1, 8'h55);
    chk("fwft_empty", empty1, 0);
    chk("fwft_count", count1, 1);
    @(posedge clk); #1;
    chk("fwft_hold", rdata1, 8'h55);
    r1 = 1;
    @(posedge clk); #1;
    r1 = 0;
    chk("fwft_pop_empty", empty1, 1);
    chk("fwft_pop_udf", udf1, 0);
    // FWFT both requests while empty
    w1 = 1; r1 = 1; wd1 = 8'h66;
    @(posedge clk); #1;
    w1 = 0; r1 = 0;
    chk("fwft_both_rdata", rdata1, 8'h66);
    chk("fwft_both_empty", empty1, 0);
    chk("fwft_both_count", count1, 1);
    chk("fwft_both_udf", udf1, 1);
    c1 = 1;
    @(posedge clk); #1;
    c1 = 0;
    chk("fwft_clr_udf", udf1, 0);
    chk("fwft_clr_rdata", rdata1, 8'h66);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
